// File: rtl/lcd_spi_serializer.sv
// lcd_spi_serializer: queues {dc,byte} entries in a small FIFO and shifts each
// byte out MSB-first on a 4-line SPI (mode 0) link to an ST7735-class panel.
// Ports:
//   clk, reset_n     - system clock, async active-low reset
//   sync_reset       - synchronous clear, same effect as reset_n
//   data_load        - one-cycle push strobe for data/dc_in
//   data, dc_in      - byte to send and its D/C flag (0 = command)
//   fifo_full        - FIFO holds FIFO_DEPTH entries
//   busy             - FIFO non-empty or serializer active
//   overflow         - sticky: a push was dropped while full
//   done             - one-cycle pulse per transmitted byte
//   csx, dcx, scl, sda - panel chip select (low), D/C, serial clock, data
module lcd_spi_serializer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sync_reset,
  input  logic       data_load,
  input  logic [7:0] data,
  input  logic       dc_in,
  output logic       fifo_full,
  output logic       busy,
  output logic       overflow,
  output logic       done,
  output logic       csx,
  output logic       dcx,
  output logic       scl,
  output logic       sda
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [8:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic [DW-1:0]   r_div;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_csx;
  logic            r_dcx;
  logic            r_scl;
  logic            r_done;
  logic            r_full;
  logic            r_busy;
  logic            r_ovf;

  logic            w_div_end;
  logic            w_fifo_ne;
  logic            w_push;
  logic [8:0]      w_head;
  logic            w_load;
  logic            w_shift;
  logic            w_rise;
  logic            w_fall;
  logic            w_done;
  logic            w_release;

  assign w_div_end   = (r_div == DW'(CLK_DIV - 1));
  assign w_fifo_ne   = (r_count != '0);
  assign w_push      = data_load & ~r_full;
  assign w_head      = r_mem[r_rd_ptr];
  // Popping only happens when a byte is loaded into the shifter.
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_load);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else if (sync_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_fifo_ne) w_state_nxt = S_LOW;
      S_LOW:  if (w_div_end) w_state_nxt = S_HIGH;
      S_HIGH: begin
        if (w_div_end) begin
          if (r_bit != 3'd7)   w_state_nxt = S_LOW;
          else if (w_fifo_ne)  w_state_nxt = S_LOW;
          else                 w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: if (w_div_end) w_state_nxt = S_IDLE;
    endcase
  end

  // Control decode driving the datapath and panel registers
  always_comb begin
    w_load    = 1'b0;
    w_shift   = 1'b0;
    w_rise    = 1'b0;
    w_fall    = 1'b0;
    w_done    = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE: w_load = w_fifo_ne;
      S_LOW:  w_rise = w_div_end;
      S_HIGH: begin
        if (w_div_end) begin
          w_fall = 1'b1;
          if (r_bit != 3'd7) begin
            w_shift = 1'b1;
          end else begin
            w_done = 1'b1;
            w_load = w_fifo_ne;
          end
        end
      end
      S_HOLD: w_release = w_div_end;
    endcase
  end

  // FIFO storage; stale writes under reset are harmless since pointers clear
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {dc_in, data};
  end

  // FIFO bookkeeping and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_busy   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (sync_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_busy   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
      // Registered copy of (count != 0) | (state != IDLE) for the coming cycle
      r_busy  <= (w_count_nxt != '0) | (w_state_nxt != S_IDLE);
      r_ovf   <= r_ovf | (data_load & r_full);
    end
  end

  // Shifter, bit/divider counters and panel pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_csx   <= 1'b1;
      r_dcx   <= 1'b0;
      r_scl   <= 1'b0;
      r_done  <= 1'b0;
    end else if (sync_reset) begin
      r_shift <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_csx   <= 1'b1;
      r_dcx   <= 1'b0;
      r_scl   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_done;
      if (r_state == S_IDLE || w_div_end) r_div <= '0;
      else                                r_div <= r_div + DW'(1);
      // sda is the shifter MSB, so new data appears only at load or scl fall
      if (w_load) begin
        r_shift <= w_head[7:0];
        r_dcx   <= w_head[8];
        r_csx   <= 1'b0;
        r_bit   <= '0;
      end else if (w_shift) begin
        r_shift <= {r_shift[6:0], 1'b0};
        r_bit   <= r_bit + 3'd1;
      end
      if (w_rise)      r_scl <= 1'b1;
      else if (w_fall) r_scl <= 1'b0;
      if (w_release) r_csx <= 1'b1;
    end
  end

  assign fifo_full = r_full;
  assign busy      = r_busy;
  assign overflow  = r_ovf;
  assign done      = r_done;
  assign csx       = r_csx;
  assign dcx       = r_dcx;
  assign scl       = r_scl;
  assign sda       = r_shift[7];

endmodule

// File: tb/tb_lcd_spi_serializer.sv
// Directed bench for lcd_spi_serializer: one instance at CLK_DIV=2 and one at
// CLK_DIV=1, each watched by a panel-side monitor that records scl edges,
// sampled sda/dcx bits, csx transitions and done pulses.
module tb_lcd_spi_serializer;

  logic       clk = 1'b0;
  logic       reset_n, sync_reset, data_load, dc_in;
  logic [7:0] data;
  logic       fifo_full, busy, overflow, done, csx, dcx, scl, sda;

  logic       sync_reset1, data_load1, dc_in1;
  logic [7:0] data1;
  logic       fifo_full1, busy1, overflow1, done1, csx1, dcx1, scl1, sda1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit mon_clr = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_spi_serializer #(.FIFO_DEPTH(4), .CLK_DIV(2)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
    .data_load(data_load), .data(data), .dc_in(dc_in),
    .fifo_full(fifo_full), .busy(busy), .overflow(overflow), .done(done),
    .csx(csx), .dcx(dcx), .scl(scl), .sda(sda)
  );

  lcd_spi_serializer #(.FIFO_DEPTH(4), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset1),
    .data_load(data_load1), .data(data1), .dc_in(dc_in1),
    .fifo_full(fifo_full1), .busy(busy1), .overflow(overflow1), .done(done1),
    .csx(csx1), .dcx(dcx1), .scl(scl1), .sda(sda1)
  );

  // Panel-side monitor for the CLK_DIV=2 instance
  int          m_rise, m_gap_bad, m_first_rise, m_rise8, m_last_rise, m_last_fall;
  int          m_csx_rise, m_csx_fall, m_csx_rise_cyc, m_csx_fall_cyc, m_csx_hi_len;
  int          m_dcx_chg, m_done, m_done_cyc, m_done_gap;
  logic [63:0] m_bits, m_dcb;
  bit          p_scl, p_csx, p_dcx;

  always @(negedge clk) begin
    if (mon_clr) begin
      m_rise <= 0; m_gap_bad <= 0; m_first_rise <= 0; m_rise8 <= 0;
      m_last_rise <= 0; m_last_fall <= 0; m_csx_rise <= 0; m_csx_fall <= 0;
      m_csx_rise_cyc <= 0; m_csx_fall_cyc <= 0; m_csx_hi_len <= 0;
      m_dcx_chg <= 0; m_done <= 0; m_done_cyc <= 0; m_done_gap <= 0;
      m_bits <= '0; m_dcb <= '0;
    end else begin
      if (scl && !p_scl) begin
        if (m_rise != 0 && (cyc - m_last_rise) != 4) m_gap_bad <= m_gap_bad + 1;
        if (m_rise == 0) m_first_rise <= cyc;
        if (m_rise == 7) m_rise8 <= cyc;
        m_last_rise <= cyc;
        m_bits <= {m_bits[62:0], sda};
        m_dcb  <= {m_dcb[62:0], dcx};
        m_rise <= m_rise + 1;
      end
      if (!scl && p_scl) m_last_fall <= cyc;
      if (csx && !p_csx) begin
        m_csx_rise <= m_csx_rise + 1;
        m_csx_rise_cyc <= cyc;
      end
      if (!csx && p_csx) begin
        m_csx_fall <= m_csx_fall + 1;
        m_csx_fall_cyc <= cyc;
        if (m_csx_rise > 0) m_csx_hi_len <= cyc - m_csx_rise_cyc;
      end
      if (dcx != p_dcx) m_dcx_chg <= cyc;
      if (done) begin
        if (m_done > 0) m_done_gap <= cyc - m_done_cyc;
        m_done_cyc <= cyc;
        m_done <= m_done + 1;
      end
    end
    p_scl <= scl;
    p_csx <= csx;
    p_dcx <= dcx;
  end

  // Panel-side monitor for the CLK_DIV=1 instance
  int          n_rise, n_gap_bad, n_last_rise, n_csx_fall, n_done;
  logic [63:0] n_bits;
  bit          q_scl, q_csx;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_rise <= 0; n_gap_bad <= 0; n_last_rise <= 0; n_csx_fall <= 0;
      n_done <= 0; n_bits <= '0;
    end else begin
      if (scl1 && !q_scl) begin
        if (n_rise != 0 && (cyc - n_last_rise) != 2) n_gap_bad <= n_gap_bad + 1;
        n_last_rise <= cyc;
        n_bits <= {n_bits[62:0], sda1};
        n_rise <= n_rise + 1;
      end
      if (!csx1 && q_csx) n_csx_fall <= n_csx_fall + 1;
      if (done1) n_done <= n_done + 1;
    end
    q_scl <= scl1;
    q_csx <= csx1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    tick();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic dc);
    data_load = 1'b1; data = d; dc_in = dc;
    tick();
    data_load = 1'b0;
  endtask

  task automatic push1(input logic [7:0] d, input logic dc);
    data_load1 = 1'b1; data1 = d; dc_in1 = dc;
    tick();
    data_load1 = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin tick(); k++; end
    check(tag, 64'(busy), 64'd0);
  endtask

  task automatic wait_rise(input string tag, input int n, input int budget);
    int k = 0;
    while (m_rise < n && k < budget) begin tick(); k++; end
    check(tag, 64'(m_rise), 64'(n));
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    int k = 0;
    while (m_done < n && k < budget) begin tick(); k++; end
    check(tag, 64'(m_done), 64'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; sync_reset = 1'b0; data_load = 1'b0; data = '0; dc_in = 1'b0;
    sync_reset1 = 1'b0; data_load1 = 1'b0; data1 = '0; dc_in1 = 1'b0;
    repeat (3) tick();
    check("rst_csx", 64'(csx), 64'd1);
    check("rst_dcx", 64'(dcx), 64'd0);
    check("rst_scl", 64'(scl), 64'd0);
    check("rst_sda", 64'(sda), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_full", 64'(fifo_full), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    tick();

    // Single byte 0xA5 as data
    clear_mon();
    push(8'hA5, 1'b1);
    check("t1_csx_before_pop", 64'(csx), 64'd1);
    tick();
    check("t1_csx_fall", 64'(csx), 64'd0);
    check("t1_dcx", 64'(dcx), 64'd1);
    wait_idle("t1_idle", 200);
    check("t1_rises", 64'(m_rise), 64'd8);
    check("t1_bits", 64'(m_bits[7:0]), 64'hA5);
    check("t1_gap", 64'(m_gap_bad), 64'd0);
    check("t1_first_rise", 64'(m_first_rise - m_csx_fall_cyc), 64'd2);
    check("t1_csx_release", 64'(m_csx_rise_cyc - m_last_fall), 64'd2);
    check("t1_done", 64'(m_done), 64'd1);
    check("t1_csx_end", 64'(csx), 64'd1);

    // Back-to-back command + data
    clear_mon();
    push(8'h2C, 1'b0);
    push(8'h12, 1'b1);
    wait_idle("t2_idle", 300);
    check("t2_rises", 64'(m_rise), 64'd16);
    check("t2_bits", 64'(m_bits[15:0]), 64'h2C12);
    check("t2_dc_bits", 64'(m_dcb[15:0]), 64'h00FF);
    check("t2_gap", 64'(m_gap_bad), 64'd0);
    check("t2_csx_fall", 64'(m_csx_fall), 64'd1);
    check("t2_csx_rise", 64'(m_csx_rise), 64'd1);
    check("t2_done", 64'(m_done), 64'd2);
    check("t2_done_gap", 64'(m_done_gap), 64'd32);
    check("t2_dcx_edge", 64'(m_dcx_chg - m_rise8), 64'd2);

    // Overflow: six consecutive pushes into a depth-4 FIFO
    clear_mon();
    push(8'h11, 1'b0);
    push(8'h22, 1'b1);
    push(8'h33, 1'b0);
    push(8'h44, 1'b1);
    push(8'h55, 1'b0);
    check("t3_full", 64'(fifo_full), 64'd1);
    check("t3_ovf_pre", 64'(overflow), 64'd0);
    push(8'h66, 1'b1);
    check("t3_ovf", 64'(overflow), 64'd1);
    wait_idle("t3_idle", 400);
    check("t3_rises", 64'(m_rise), 64'd40);
    check("t3_bits", 64'(m_bits[39:0]), 64'h1122334455);
    check("t3_done", 64'(m_done), 64'd5);
    check("t3_ovf_sticky", 64'(overflow), 64'd1);
    check("t3_full_end", 64'(fifo_full), 64'd0);
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    check("t3_ovf_clr", 64'(overflow), 64'd0);

    // Push while the link is in HOLD
    clear_mon();
    push(8'h3A, 1'b0);
    wait_done("t5_first_done", 1, 200);
    push(8'hC5, 1'b1);
    wait_idle("t5_idle", 200);
    check("t5_csx_rise", 64'(m_csx_rise), 64'd2);
    check("t5_csx_fall", 64'(m_csx_fall), 64'd2);
    check("t5_csx_hi", 64'(m_csx_hi_len), 64'd1);
    check("t5_done", 64'(m_done), 64'd2);
    check("t5_bits", 64'(m_bits[15:0]), 64'h3AC5);
    check("t5_dc_bits", 64'(m_dcb[15:0]), 64'h00FF);

    // sync_reset mid-byte with two entries still queued
    clear_mon();
    push(8'hF0, 1'b0);
    push(8'h0F, 1'b1);
    push(8'hAA, 1'b0);
    wait_rise("t4_rise3", 3, 100);
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    check("t4_csx", 64'(csx), 64'd1);
    check("t4_scl", 64'(scl), 64'd0);
    check("t4_sda", 64'(sda), 64'd0);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_full", 64'(fifo_full), 64'd0);
    repeat (40) tick();
    check("t4_no_rise", 64'(m_rise), 64'd3);
    check("t4_no_done", 64'(m_done), 64'd0);

    // Same again with asynchronous reset_n, checked before the next clock edge
    clear_mon();
    push(8'hF0, 1'b0);
    push(8'h0F, 1'b1);
    push(8'hAA, 1'b0);
    wait_rise("t4a_rise3", 3, 100);
    #2 reset_n = 1'b0;
    #1;
    check("t4a_csx", 64'(csx), 64'd1);
    check("t4a_scl", 64'(scl), 64'd0);
    check("t4a_sda", 64'(sda), 64'd0);
    check("t4a_busy", 64'(busy), 64'd0);
    tick();
    reset_n = 1'b1;
    repeat (40) tick();
    check("t4a_no_rise", 64'(m_rise), 64'd3);
    check("t4a_no_done", 64'(m_done), 64'd0);
    check("t4a_csx_idle", 64'(csx), 64'd1);

    // CLK_DIV=1 burst of four bytes
    clear_mon();
    push1(8'h81, 1'b0);
    push1(8'h7E, 1'b1);
    push1(8'hC3, 1'b1);
    push1(8'h3C, 1'b0);
    begin
      int k = 0;
      while (busy1 && k < 200) begin tick(); k++; end
    end
    check("t6_idle", 64'(busy1), 64'd0);
    check("t6_rises", 64'(n_rise), 64'd32);
    check("t6_bits", 64'(n_bits[31:0]), 64'h817EC33C);
    check("t6_gap", 64'(n_gap_bad), 64'd0);
    check("t6_csx_fall", 64'(n_csx_fall), 64'd1);
    check("t6_done", 64'(n_done), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
